// File: rtl/cache_pkg.sv
// cache_pkg: shared types, sizes and way-vector
// helpers for the lookup/refill controller.
package cache_pkg;

  localparam int CACHE_ADDR_W   = 8;
  localparam int CACHE_INDEX_W  = 2;
  localparam int CACHE_OFFSET_W = 2;
  localparam int CACHE_WAYS     = 4;

  localparam int TAG_W =
    CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W;
  localparam int SETS      = 1 << CACHE_INDEX_W;
  localparam int WAY_IDX_W = $clog2(CACHE_WAYS);

  typedef logic [CACHE_WAYS-1:0] way_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_WAIT = 3'd2,
    FILL      = 3'd3,
    DONE      = 3'd4
  } miss_state_t;

  function automatic logic is_onehot(input way_t v);
    return (v != '0) && ((v & (v - way_t'(1))) == '0);
  endfunction

  function automatic logic [WAY_IDX_W-1:0]
    onehot_to_idx(input way_t v);
    logic [WAY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CACHE_WAYS; i++) begin
      if (v[i]) idx = idx | WAY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: tag + valid arrays with a
// combinational set compare and one-way write.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [CACHE_INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]         tag,
  input  logic                     wr,
  input  logic [CACHE_WAYS-1:0]    way,
  output logic [CACHE_WAYS-1:0]    match
);

  logic [TAG_W-1:0]      tags  [SETS][CACHE_WAYS];
  logic [CACHE_WAYS-1:0] valid [SETS];

  // Compare the request tag against every valid way of the set
  always_comb begin
    match = '0;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      match[w] = valid[index][w] && (tags[index][w] == tag);
    end
  end

  // Valid bits: cleared by reset or flush, set on fill
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (wr) begin
      valid[index] <= valid[index] | way;
    end
  end

  // Tag array: written only into the victim way on fill
  always_ff @(posedge clk) begin
    if (wr) tags[index][onehot_to_idx(way)] <= tag;
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: hit/miss resolution, memory read
// handshake and refill toward the replacement block.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = CACHE_ADDR_W,
  parameter int INDEX_W  = CACHE_INDEX_W,
  parameter int OFFSET_W = CACHE_OFFSET_W,
  parameter int WAYS     = CACHE_WAYS,
  parameter int TIMEOUT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_flush,
  output logic               o_ready,
  output logic               o_ack,
  output logic               o_hit,
  output logic [WAYS-1:0]    o_way,
  output logic               o_err,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic               i_mem_ack,
  output logic               o_modify,
  output logic [INDEX_W-1:0] o_index,
  output logic               o_block,
  input  logic [WAYS-1:0]    i_en_wr
);

  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam int TAG_LO = INDEX_W + OFFSET_W;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFFSET_W) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  miss_state_t state, state_nxt;

  logic [ADDR_W-1:0]        req_addr;
  logic [CNT_W-1:0]         cnt;
  logic [WAYS-1:0]          fill_way;
  logic [WAYS-1:0]          match;
  logic [WAYS-1:0]          first;
  logic [INDEX_W-1:0]       req_index;
  logic [ADDR_W-TAG_LO-1:0] req_tag;
  logic accept, flush, hit, timeout, fill_ok, tag_wr;

  assign req_tag   = req_addr[ADDR_W-1:TAG_LO];
  assign req_index = req_addr[TAG_LO-1:OFFSET_W];
  assign flush     = (state == IDLE) && i_flush;
  assign accept    = (state == IDLE) && i_req && !i_flush;
  assign hit       = |match;
  // Lowest set bit: a corrupt store with duplicates
  // still resolves to a single way
  assign first     = match & (~match + WAYS'(1));
  assign timeout   = !i_mem_ack && (cnt == CNT_LAST);
  assign fill_ok   = is_onehot(i_en_wr);
  assign tag_wr    = (state == FILL) && fill_ok;

  cache_tag_store u_store (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (flush),
    .index (req_index),
    .tag   (req_tag),
    .wr    (tag_wr),
    .way   (i_en_wr),
    .match (match)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request address, miss-wait counter and filled way
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_addr <= '0;
      cnt      <= '0;
      fill_way <= '0;
    end else begin
      if (accept) req_addr <= i_addr;
      if (state == MISS_WAIT) cnt <= cnt + CNT_W'(1);
      else                    cnt <= '0;
      if (tag_wr) fill_way <= i_en_wr;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = LOOKUP;
      LOOKUP:    state_nxt = hit ? IDLE : MISS_WAIT;
      MISS_WAIT: begin
        if (i_mem_ack)    state_nxt = FILL;
        else if (timeout) state_nxt = IDLE;
      end
      FILL:      state_nxt = fill_ok ? DONE : IDLE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode per state
  always_comb begin
    o_ready    = 1'b0;
    o_ack      = 1'b0;
    o_hit      = 1'b0;
    o_way      = '0;
    o_err      = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_addr = '0;
    o_modify   = 1'b0;
    o_block    = 1'b0;
    o_index    = req_index;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_index = '0;
      end
      LOOKUP: begin
        if (hit) begin
          o_ack = 1'b1;
          o_hit = 1'b1;
          o_way = first;
          o_err = !is_onehot(match);
        end
      end
      MISS_WAIT: begin
        o_mem_req  = 1'b1;
        o_mem_addr = req_addr & ~OFF_MASK;
        o_err      = timeout;
      end
      FILL: begin
        o_modify = 1'b1;
        o_block  = 1'b1;
        o_err    = !fill_ok;
      end
      DONE: begin
        o_ack = 1'b1;
        o_way = fill_way;
      end
      default: ;
    endcase
  end

endmodule
